// File: rtl/qsys_width_bridge_pkg.sv
// Shared types and lane-walk helpers for the Qsys width bridge.
package qsys_bridge_pkg;

  // Upper bound on lanes; masks are zero-padded to this width for the helpers.
  localparam int MAX_LANES = 32;

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic lane_active(input lane_mask_t mask, input int i);
    return mask[i];
  endfunction

  // Lowest active lane strictly above cur, or nlanes when none remain.
  function automatic int next_lane(input lane_mask_t mask, input int cur, input int nlanes);
    int r;
    r = nlanes;
    for (int i = MAX_LANES - 1; i >= 0; i--)
      if (i > cur && i < nlanes && lane_active(mask, i)) r = i;
    return r;
  endfunction

endpackage

// File: rtl/qsys_width_bridge_if.sv
// Avalon-MM control-port bundle between the Qsys fabric and the bridge.
interface qsys_width_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int AVS_DW = 32
);
  logic [ADDR_W-1:0]   avs_ctrl_address;
  logic [AVS_DW-1:0]   avs_ctrl_writedata;
  logic [AVS_DW/8-1:0] avs_ctrl_byteenable;
  logic                avs_ctrl_write;
  logic                avs_ctrl_read;
  logic [AVS_DW-1:0]   avs_ctrl_readdata;
  logic                avs_ctrl_waitrequest;

  modport slave (
    input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read,
    output avs_ctrl_readdata, avs_ctrl_waitrequest
  );

  modport master (
    output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest
  );
endinterface

// File: rtl/qsys_width_bridge_lane_timer.sv
// Per-lane stall watchdog: reloaded at each lane start, counts stalled cycles down.
module qsys_lane_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Reload on lane start, otherwise decrement on each stalled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = TW'(TIMEOUT);
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  // Fires in the TIMEOUT-th stalled cycle; TIMEOUT of 0 never fires.
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == TW'(1));

endmodule

// File: rtl/qsys_width_bridge.sv
// Splits wide Avalon accesses into per-lane narrow device accesses, LSB lane first.
module qsys_width_bridge
  import qsys_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int AVS_DW  = 32,
  parameter int DEV_DW  = 8,
  parameter int TIMEOUT = 255,
  localparam int LANES  = AVS_DW / DEV_DW,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int BPL    = DEV_DW / 8
) (
  input  logic                   csi_MCLK_clk,
  input  logic                   rsi_MRST_reset_n,
  qsys_width_bridge_if.slave     avs,
  output logic                   device_reset_n,
  output logic                   device_clk,
  output logic [ADDR_W+LW-1:0]   device_address,
  output logic [DEV_DW-1:0]      device_writedata,
  output logic                   device_write,
  output logic                   device_read,
  input  logic [DEV_DW-1:0]      device_readdata,
  input  logic                   device_waitrequest,
  output logic                   bridge_timeout
);

  logic rst_meta_q, rst_sync_q;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [AVS_DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LANES-1:0]  mask_q, mask_d, be_mask;
  logic [LW-1:0]     lane_q, lane_d;
  logic              rd_q, rd_d, dev_rd_q, dev_rd_d, dev_wr_q, dev_wr_d, tmo_q, tmo_d;
  logic [ADDR_W+LW-1:0] dev_addr_q, dev_addr_d;
  logic [DEV_DW-1:0] dev_wdata_q, dev_wdata_d;
  logic              req, strobe, tmr_load, expire;
  int                nxt;

  assign device_reset_n = rsi_MRST_reset_n;
  assign device_clk     = csi_MCLK_clk;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n)
    if (!rsi_MRST_reset_n) {rst_sync_q, rst_meta_q} <= 2'b00;
    else                   {rst_sync_q, rst_meta_q} <= {rst_meta_q, 1'b1};

  assign req    = avs.avs_ctrl_read | avs.avs_ctrl_write;
  assign strobe = dev_rd_q | dev_wr_q;
  assign avs.avs_ctrl_waitrequest = req & (state_q != DONE);
  assign avs.avs_ctrl_readdata    = rdata_q;

  // A lane is active if any of its bytes is enabled.
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < LANES; i++) be_mask[i] = |avs.avs_ctrl_byteenable[i*BPL +: BPL];
  end

  qsys_lane_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i(csi_MCLK_clk), .rst_ni(rst_sync_q),
    .load_i(tmr_load), .en_i(strobe & device_waitrequest), .expire_o(expire)
  );

  // Transaction FSM: latch request, walk active lanes, present result for one cycle.
  always_comb begin
    state_d = state_q;   addr_d = addr_q;   wdata_d = wdata_q;  mask_d = mask_q;
    rd_d = rd_q;         rdata_d = rdata_q; lane_d = lane_q;
    dev_rd_d = dev_rd_q; dev_wr_d = dev_wr_q;
    dev_addr_d = dev_addr_q; dev_wdata_d = dev_wdata_q;
    tmo_d = 1'b0; tmr_load = 1'b0; nxt = LANES;
    unique case (state_q)
      IDLE: if (req) begin
        addr_d  = avs.avs_ctrl_address;
        wdata_d = avs.avs_ctrl_writedata;
        mask_d  = be_mask;
        rd_d    = avs.avs_ctrl_read;  // read wins over a simultaneous write
        rdata_d = '0;
        nxt = next_lane(lane_mask_t'(be_mask), -1, LANES);
        if (nxt < LANES) begin
          lane_d      = LW'(nxt);
          dev_rd_d    = avs.avs_ctrl_read;
          dev_wr_d    = ~avs.avs_ctrl_read;
          dev_addr_d  = {avs.avs_ctrl_address, LW'(nxt)};
          dev_wdata_d = avs.avs_ctrl_writedata[nxt*DEV_DW +: DEV_DW];
          tmr_load    = 1'b1;
          state_d     = ACCESS;
        end else begin
          state_d = DONE;
        end
      end
      ACCESS: begin
        if (!strobe) begin
          // Gap cycle between lanes: re-raise the strobe for the new lane.
          dev_rd_d = rd_q;
          dev_wr_d = ~rd_q;
          tmr_load = 1'b1;
        end else if (!device_waitrequest || expire) begin
          if (rd_q) rdata_d[lane_q*DEV_DW +: DEV_DW] = expire ? '1 : device_readdata;
          tmo_d    = expire;
          dev_rd_d = 1'b0;
          dev_wr_d = 1'b0;
          nxt = next_lane(lane_mask_t'(mask_q), int'(lane_q), LANES);
          if (nxt < LANES) begin
            lane_d      = LW'(nxt);
            dev_addr_d  = {addr_q, LW'(nxt)};
            dev_wdata_d = wdata_q[nxt*DEV_DW +: DEV_DW];
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered device-side outputs.
  always_ff @(posedge csi_MCLK_clk or negedge rst_sync_q)
    if (!rst_sync_q) begin
      state_q <= IDLE;  addr_q <= '0;  wdata_q <= '0;  mask_q <= '0;  rd_q <= 1'b0;
      rdata_q <= '0;    lane_q <= '0;  dev_rd_q <= 1'b0; dev_wr_q <= 1'b0;
      dev_addr_q <= '0; dev_wdata_q <= '0; tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  mask_q <= mask_d;  rd_q <= rd_d;
      rdata_q <= rdata_d;  lane_q <= lane_d;  dev_rd_q <= dev_rd_d; dev_wr_q <= dev_wr_d;
      dev_addr_q <= dev_addr_d; dev_wdata_q <= dev_wdata_d; tmo_q <= tmo_d;
    end

  assign device_read      = dev_rd_q;
  assign device_write     = dev_wr_q;
  assign device_address   = dev_addr_q;
  assign device_writedata = dev_wdata_q;
  assign bridge_timeout   = tmo_q;

endmodule

// File: tb/tb_qsys_width_bridge.sv
// Directed vector bench for qsys_width_bridge with a stalling byte-wide device model.
module tb_qsys_width_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qsys_width_bridge_if #(.ADDR_W(8), .AVS_DW(32)) bus ();

  logic        device_reset_n, device_clk, device_write, device_read;
  logic        device_waitrequest, bridge_timeout;
  logic [9:0]  device_address;
  logic [7:0]  device_writedata, device_readdata;

  qsys_width_bridge #(.ADDR_W(8), .AVS_DW(32), .DEV_DW(8), .TIMEOUT(4)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n), .avs(bus),
    .device_reset_n(device_reset_n), .device_clk(device_clk),
    .device_address(device_address), .device_writedata(device_writedata),
    .device_write(device_write), .device_read(device_read),
    .device_readdata(device_readdata), .device_waitrequest(device_waitrequest),
    .bridge_timeout(bridge_timeout)
  );

  // Device model: per-lane stall count (8'hFF = never ready), per-lane read value.
  logic [7:0] rd_val [4];
  logic [7:0] stall  [4];
  int wcnt = 0, wr_cnt = 0, to_cnt = 0;
  logic [9:0] log_addr [$];
  logic [7:0] log_data [$];
  logic       log_we   [$];

  assign device_readdata    = rd_val[device_address[1:0]];
  assign device_waitrequest = (device_read || device_write) && (wcnt < int'(stall[device_address[1:0]]));

  always @(posedge clk) begin
    if (device_read || device_write) begin
      if (device_waitrequest) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        log_addr.push_back(device_address);
        log_data.push_back(device_write ? device_writedata : device_readdata);
        log_we.push_back(device_write);
      end
    end else wcnt <= 0;
    if (device_write)   wr_cnt <= wr_cnt + 1;
    if (bridge_timeout) to_cnt <= to_cnt + 1;
  end

  typedef struct {
    logic        rd, wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rv;     // device read byte per lane
    logic [31:0] stl;    // stall cycles per lane, FF = stuck
    int          cyc;    // request cycle .. waitrequest-low cycle
    logic [31:0] rdata;
    int          nacc;   // completed device accesses
    int          ntmo;
  } vec_t;

  int n_vec = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int a0, w0, t0, cyc, idx;
    logic [31:0] rdat;
    bit ok;
    for (int l = 0; l < 4; l++) begin
      rd_val[l] = v.rv[l*8 +: 8];
      stall[l]  = v.stl[l*8 +: 8];
    end
    a0 = log_addr.size(); w0 = wr_cnt; t0 = to_cnt;
    @(negedge clk);
    bus.avs_ctrl_address = v.addr;  bus.avs_ctrl_writedata = v.wd;
    bus.avs_ctrl_byteenable = v.be; bus.avs_ctrl_read = v.rd; bus.avs_ctrl_write = v.wr;
    #1; cyc = 1;
    while (bus.avs_ctrl_waitrequest && cyc < 200) begin @(negedge clk); cyc++; end
    rdat = bus.avs_ctrl_readdata;
    @(posedge clk); #1;
    bus.avs_ctrl_read = 1'b0; bus.avs_ctrl_write = 1'b0;
    @(negedge clk);
    check({tag, ".cycles"}, 64'(cyc), 64'(v.cyc));
    check({tag, ".rdata"}, 64'(rdat), 64'(v.rdata));
    check({tag, ".naccess"}, 64'(log_addr.size() - a0), 64'(v.nacc));
    check({tag, ".ntimeout"}, 64'(to_cnt - t0), 64'(v.ntmo));
    if (v.rd) check({tag, ".nwrite"}, 64'(wr_cnt - w0), 64'd0);
    ok = 1'b1; idx = a0;
    for (int l = 0; l < 4; l++)
      if (v.be[l] && v.stl[l*8 +: 8] != 8'hFF) begin
        if (idx >= log_addr.size()) ok = 1'b0;
        else begin
          if (log_addr[idx] !== {v.addr, 2'(l)})                  ok = 1'b0;
          if (log_we[idx] !== (v.wr && !v.rd))                    ok = 1'b0;
          if (log_we[idx] && log_data[idx] !== v.wd[l*8 +: 8])    ok = 1'b0;
        end
        idx++;
      end
    check({tag, ".sequence"}, 64'(ok), 64'd1);
  endtask

  vec_t vecs [8];
  vec_t r;
  int   cyc, sum;

  initial begin
    //           rd    wr    addr   wd            be    rv            stalls        cyc rdata         nacc ntmo
    vecs[0] = '{1'b0, 1'b1, 8'h0A, 32'hA1B2C3D4, 4'hF, 32'h0,        32'h0,        9,  32'h0,        4,   0};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h5, 32'h44332211, 32'h0,        5,  32'h00330011, 2,   0};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h0,        2,  32'h0,        0,   0};
    vecs[3] = '{1'b1, 1'b0, 8'h22, 32'h0,        4'hF, 32'h44332211, 32'h0000FF00, 12, 32'h4433FF11, 3,   1};
    vecs[4] = '{1'b1, 1'b0, 8'h23, 32'h0,        4'hF, 32'h89ABCDEF, 32'h03010002, 15, 32'h89ABCDEF, 4,   0};
    vecs[5] = '{1'b0, 1'b1, 8'h24, 32'h12345678, 4'h6, 32'h0,        32'h00000100, 6,  32'h0,        2,   0};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'h8, 32'hDEADBEEF, 32'h0,        3,  32'hDE000000, 1,   0};
    vecs[7] = '{1'b1, 1'b1, 8'h5A, 32'h55555555, 4'hF, 32'hCAFEF00D, 32'h00020001, 12, 32'hCAFEF00D, 4,   0};

    for (int l = 0; l < 4; l++) begin rd_val[l] = 8'h00; stall[l] = 8'h00; end
    bus.avs_ctrl_address = '0; bus.avs_ctrl_writedata = '0; bus.avs_ctrl_byteenable = '0;
    bus.avs_ctrl_read = 1'b0;  bus.avs_ctrl_write = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.device_reset_n", 64'(device_reset_n), 64'd0);
    check("rst.read",    64'(device_read), 64'd0);
    check("rst.write",   64'(device_write), 64'd0);
    check("rst.address", 64'(device_address), 64'd0);
    check("rst.wdata",   64'(device_writedata), 64'd0);
    check("rst.timeout", 64'(bridge_timeout), 64'd0);
    check("rst.rdata",   64'(bus.avs_ctrl_readdata), 64'd0);
    check("rst.waitreq", 64'(bus.avs_ctrl_waitrequest), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Read+write with random device stalls behaves as a read.
    for (int k = 0; k < 3; k++) begin
      r.rd = 1'b1; r.wr = 1'b1; r.addr = 8'($urandom_range(0, 255));
      r.wd = $urandom; r.be = 4'hF; r.rv = $urandom; sum = 0;
      for (int l = 0; l < 4; l++) begin
        r.stl[l*8 +: 8] = 8'($urandom_range(0, 3));
        sum += int'(r.stl[l*8 +: 8]);
      end
      r.cyc = 9 + sum; r.rdata = r.rv; r.nacc = 4; r.ntmo = 0;
      run_vec(r, $sformatf("rw%0d", k));
    end

    // Reset while lane 2 is being read.
    for (int l = 0; l < 4; l++) begin rd_val[l] = 8'(8'h70 + l); stall[l] = 8'h00; end
    @(negedge clk);
    bus.avs_ctrl_address = 8'h33; bus.avs_ctrl_writedata = 32'h87654321;
    bus.avs_ctrl_byteenable = 4'hF; bus.avs_ctrl_read = 1'b1;
    cyc = 0;
    while (!(device_read && device_address[1:0] == 2'd2) && cyc < 50) begin @(negedge clk); cyc++; end
    check("mid.reach_lane2", 64'(cyc < 50), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid.read_async", 64'(device_read), 64'd0);
    check("mid.device_reset_n", 64'(device_reset_n), 64'd0);
    bus.avs_ctrl_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid.address", 64'(device_address), 64'd0);
    check("mid.wdata",   64'(device_writedata), 64'd0);
    check("mid.rdata",   64'(bus.avs_ctrl_readdata), 64'd0);
    check("mid.read",    64'(device_read), 64'd0);
    check("mid.waitreq", 64'(bus.avs_ctrl_waitrequest), 64'd0);
    run_vec(vecs[6], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/qsys_width_bridge.md
Name: qsys_width_bridge

Overview:
- Avalon-MM slave that adapts a wide Qsys control bus (AVS_DW) to a narrow peripheral bus (DEV_DW).
- Each Avalon access is split into one device access per enabled lane, issued LSB lane first.
- Holds avs_ctrl_waitrequest until every lane completes, and reassembles read data.
- Bounds device stalls with a per-lane timeout. Sits between the Qsys interconnect and the team's 8/16-bit register-file peripherals.

Parameters:
- ADDR_W, 8, Avalon word-address width.
- AVS_DW, 32, Avalon data width; must be a multiple of DEV_DW.
- DEV_DW, 8, device data width; must be 8, 16 or 32.
- TIMEOUT, 255, max cycles device_waitrequest may stay high per lane; 0 disables the timeout.
- Derived: LANES = AVS_DW/DEV_DW; LW = clog2(LANES), with a minimum of 1; BPL = DEV_DW/8 (bytes per lane).

Ports:
- csi_MCLK_clk  in  1  single clock, rising edge.
- rsi_MRST_reset_n  in  1  asynchronous active-low reset.
- avs_ctrl_address  in  ADDR_W  Avalon word address.
- avs_ctrl_writedata  in  AVS_DW  write data.
- avs_ctrl_byteenable  in  AVS_DW/8  byte enables.
- avs_ctrl_write  in  1  write request.
- avs_ctrl_read  in  1  read request.
- avs_ctrl_readdata  out  AVS_DW  read data, valid in the cycle waitrequest is low with read high.
- avs_ctrl_waitrequest  out  1  stall.
- device_reset_n  out  1  equals rsi_MRST_reset_n.
- device_clk  out  1  equals csi_MCLK_clk.
- device_address  out  ADDR_W+LW  {avs_ctrl_address, lane index}.
- device_writedata  out  DEV_DW  lane data.
- device_write  out  1  device write strobe.
- device_read  out  1  device read strobe.
- device_readdata  in  DEV_DW  device read data.
- device_waitrequest  in  1  device stall.
- bridge_timeout  out  1  one-cycle pulse per timed-out lane.

Behaviour:
- Reset (async assert, sync deassert inside): state IDLE; device_write/read 0; device_address 0; device_writedata 0; readdata register 0; lane counter 0; timeout counter 0; bridge_timeout 0.
- Lane enable: lane i is active iff any byteenable bit in [i*BPL +: BPL] is 1. Partially enabled lanes are issued as full lanes.
- avs_ctrl_waitrequest = (avs_ctrl_read | avs_ctrl_write) & (state != DONE), combinational. It is 1 in the request cycle itself.
- Simultaneous read and write: treated as read; write is ignored.
- FSM states:
  - IDLE: on read|write, latch address, writedata, byteenable mask and direction; clear the readdata register. If any lane is active, find the lowest active lane and go to ACCESS; otherwise go to DONE.
  - ACCESS:
    - Drive device_address = {addr, lane}, device_writedata = the lane slice, and device_read or device_write high (registered outputs).
    - Lane completes in the first cycle device_waitrequest = 0 with the strobe high. On a read, capture device_readdata into slice [lane*DEV_DW +: DEV_DW].
    - On completion, advance to the next higher active lane; strobes drop for 1 cycle between lanes. After the last active lane, go to DONE.
    - Timeout counter counts cycles with strobe high and waitrequest high. On reaching TIMEOUT: abort the lane, pulse bridge_timeout, load all-ones into that read slice, continue to the next lane.
  - DONE: waitrequest is low for exactly 1 cycle and readdata is presented; return to IDLE. The master must drop or renew its request after this cycle.
- Latency: an uncontended access with k active lanes completes in 2k+1 cycles from request to the waitrequest-low cycle. A request with no active lanes completes in 2 cycles.
- Inactive lanes read back 0.
- Address, data and mask are latched in IDLE; changes on the Avalon inputs mid-transaction are ignored.
- Reset mid-transaction: strobes drop immediately (async), state returns to IDLE, and the partial transaction is discarded.
- LANES = 1: lane index bit is constant 0; behaviour is otherwise identical.

Decomposition:
- Package qsys_bridge_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - function lane_active(mask, i)
  - function next_lane(mask, cur), returning the lowest active lane above cur, or LANES if none remain
- One sub-module, qsys_lane_timer: loadable down-counter with a TIMEOUT parameter and expire pulse, instanced once.

Test Plan:
- Write 0xA1B2C3D4, byteenable 0xF, device waitrequest 0 → 4 device writes at addresses {A,0..3} with data D4,C3,B2,A1; waitrequest low on cycle 9.
- Read, byteenable 0x5, device returns 0x11 for lane 0 and 0x33 for lane 2 → 2 accesses only; readdata 0x00330011.
- Write with byteenable 0x0 → no device strobe; waitrequest low in cycle 2.
- Read, lane 1 device_waitrequest held high, TIMEOUT=4 → bridge_timeout pulses once; slice [15:8]=0xFF; remaining lanes complete normally.
- Read and write both high, device waitrequest random 0–3 cycles → read-only behaviour with correct reassembled data; device_write never asserted.
- Assert reset in ACCESS lane 2 → device_read falls the same cycle; after release, state is IDLE and all outputs are at reset values.
